// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: turns one vector command into LANES scalar
// memory accesses at BASE + i*STRIDE, gathering into VOUT or scattering VIN.
module vector_mem_sequencer #(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                OP,
  input  logic [AW-1:0]       BASE,
  input  logic [AW-1:0]       STRIDE,
  input  logic [LANES*DW-1:0] VIN,
  output logic [LANES*DW-1:0] VOUT,
  output logic                BUSY,
  output logic                DONE,
  output logic                MEM_WE,
  output logic [AW-1:0]       MEM_A,
  output logic [DW-1:0]       MEM_WD,
  input  logic [DW-1:0]       MEM_RD
);

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_op;
  logic [AW-1:0]       r_addr;
  logic [AW-1:0]       r_stride;
  logic [LW-1:0]       r_lane;
  logic [LANES*DW-1:0] r_vin;
  logic [LANES*DW-1:0] r_vout;

  logic                w_accept;
  logic                w_busy;
  logic                w_done;
  logic                w_we;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_wd;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Memory-side outputs are forced to zero outside ACCESS so no stray write
  // can occur; they follow r_state, so an async reset clears them at once.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wd         = '0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_accept     = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_busy = 1'b1;
        w_addr = r_addr;
        w_we   = r_op;
        if (r_op) w_wd = r_vin[int'(r_lane)*DW +: DW];
        if (r_lane == LAST_LANE) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op     <= 1'b0;
      r_addr   <= '0;
      r_stride <= '0;
      r_lane   <= '0;
      r_vin    <= '0;
      r_vout   <= '0;
    end else if (w_accept) begin
      r_op     <= OP;
      r_addr   <= BASE;
      r_stride <= STRIDE;
      r_lane   <= '0;
      r_vin    <= VIN;
    end else if (r_state == S_ACCESS) begin
      r_addr <= r_addr + r_stride;
      r_lane <= r_lane + 1'b1;
      if (!r_op) r_vout[int'(r_lane)*DW +: DW] <= MEM_RD;
    end
  end

  assign VOUT   = r_vout;
  assign BUSY   = w_busy;
  assign DONE   = w_done;
  assign MEM_WE = w_we;
  assign MEM_A  = w_addr;
  assign MEM_WD = w_wd;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a small combinational-read
// word memory attached to the scalar port.
module tb_vector_mem_sequencer;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic         OP;
  logic [31:0]  BASE;
  logic [31:0]  STRIDE;
  logic [127:0] VIN;
  logic [127:0] VOUT;
  logic         BUSY;
  logic         DONE;
  logic         MEM_WE;
  logic [31:0]  MEM_A;
  logic [31:0]  MEM_WD;
  logic [31:0]  MEM_RD;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  bit          mem_inited = 1'b0;

  always #5 CLK = ~CLK;

  vector_mem_sequencer #(.LANES(4), .DW(32), .AW(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .BASE(BASE),
    .STRIDE(STRIDE), .VIN(VIN), .VOUT(VOUT), .BUSY(BUSY), .DONE(DONE),
    .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  // Memory preloads 1000+7*i once during the initial reset, then takes writes.
  always @(posedge CLK) begin
    if (!mem_inited) begin
      if (!RST_N) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'(1000 + 7 * i);
        mem_inited <= 1'b1;
      end
    end else if (MEM_WE) begin
      mem[MEM_A[5:0]] <= MEM_WD;
    end
  end

  always_comb MEM_RD = mem[MEM_A[5:0]];

  task automatic issue(input logic op, input logic [31:0] base,
                       input logic [31:0] stride, input logic [127:0] vin);
    @(negedge CLK);
    START = 1'b1; OP = op; BASE = base; STRIDE = stride; VIN = vin;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; OP = 1'b0; BASE = '0; STRIDE = '0; VIN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if ({BUSY, DONE, MEM_WE} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {BUSY, DONE, MEM_WE}); end
    checks++; if (MEM_A !== 32'd0 || MEM_WD !== 32'd0) begin errors++;
      $display("FAIL reset_mem: A=%h WD=%h expected 0/0", MEM_A, MEM_WD); end
    checks++; if (VOUT !== 128'd0) begin errors++;
      $display("FAIL reset_vout: got %h expected 0", VOUT); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_store_basic();
    issue(1'b1, 32'd0, 32'd1, {32'd40, 32'd30, 32'd20, 32'd10});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if ({BUSY, MEM_WE, DONE} !== 3'b110) begin errors++;
        $display("FAIL store_ctrl lane%0d: busy/we/done=%b expected 110", i, {BUSY, MEM_WE, DONE}); end
      checks++; if (MEM_A !== 32'(i) || MEM_WD !== 32'(10 * (i + 1))) begin errors++;
        $display("FAIL store_data lane%0d: A=%0d WD=%0d expected %0d/%0d", i, MEM_A, MEM_WD, i, 10 * (i + 1)); end
    end
    @(negedge CLK);
    checks++; if ({DONE, BUSY, MEM_WE} !== 3'b100 || MEM_A !== 32'd0) begin errors++;
      $display("FAIL store_done: done/busy/we=%b A=%h expected 100 A=0", {DONE, BUSY, MEM_WE}, MEM_A); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin errors++;
      $display("FAIL store_done_pulse: DONE=%b expected 0", DONE); end
    checks++; if (mem[0] !== 32'd10 || mem[1] !== 32'd20 || mem[2] !== 32'd30 || mem[3] !== 32'd40) begin errors++;
      $display("FAIL store_mem: %0d %0d %0d %0d expected 10 20 30 40", mem[0], mem[1], mem[2], mem[3]); end
    checks++; if (VOUT !== 128'd0) begin errors++;
      $display("FAIL store_vout: got %h expected 0", VOUT); end
  endtask

  task automatic test_load_basic();
    issue(1'b0, 32'd0, 32'd1, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if ({BUSY, MEM_WE, DONE} !== 3'b100 || MEM_A !== 32'(i)) begin errors++;
        $display("FAIL load lane%0d: busy/we/done=%b A=%0d expected 100 A=%0d", i, {BUSY, MEM_WE, DONE}, MEM_A, i); end
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++;
      $display("FAIL load_done: DONE=%b BUSY=%b expected 1/0", DONE, BUSY); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin errors++;
      $display("FAIL load_done_pulse: DONE=%b expected 0", DONE); end
    checks++; if (VOUT !== {32'd40, 32'd30, 32'd20, 32'd10}) begin errors++;
      $display("FAIL load_vout: got %h expected lanes 10,20,30,40", VOUT); end
  endtask

  task automatic test_load_stride();
    logic [31:0] exp_a [4];
    exp_a = '{32'd2, 32'd5, 32'd8, 32'd11};
    issue(1'b0, 32'd2, 32'd3, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (MEM_A !== exp_a[i] || MEM_WE !== 1'b0) begin errors++;
        $display("FAIL stride_addr lane%0d: A=%0d WE=%b expected %0d/0", i, MEM_A, MEM_WE, exp_a[i]); end
    end
    repeat (2) @(negedge CLK);
    // mem[2]=30 from the first store; 5,8,11 still hold the preload.
    checks++; if (VOUT !== {32'd1077, 32'd1056, 32'd1035, 32'd30}) begin errors++;
      $display("FAIL stride_vout: got %h expected lanes 30,1035,1056,1077", VOUT); end
  endtask

  task automatic test_store_wrap();
    logic [31:0] exp_a [4];
    exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    issue(1'b1, 32'hFFFF_FFFE, 32'd1, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (MEM_A !== exp_a[i] || MEM_WE !== 1'b1 || MEM_WD !== 32'(i + 1)) begin errors++;
        $display("FAIL wrap lane%0d: A=%h WE=%b WD=%0d expected %h/1/%0d", i, MEM_A, MEM_WE, MEM_WD, exp_a[i], i + 1); end
    end
    repeat (2) @(negedge CLK);
    checks++; if (VOUT !== {32'd1077, 32'd1056, 32'd1035, 32'd30}) begin errors++;
      $display("FAIL wrap_vout_held: got %h expected previous load result", VOUT); end
    checks++; if (mem[62] !== 32'd1 || mem[63] !== 32'd2 || mem[0] !== 32'd3 || mem[1] !== 32'd4) begin errors++;
      $display("FAIL wrap_mem: %0d %0d %0d %0d expected 1 2 3 4", mem[62], mem[63], mem[0], mem[1]); end
  endtask

  task automatic test_start_ignored();
    issue(1'b0, 32'd0, 32'd1, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (MEM_A !== 32'(i) || MEM_WE !== 1'b0 || BUSY !== 1'b1) begin errors++;
        $display("FAIL ignore lane%0d: A=%0d WE=%b BUSY=%b expected %0d/0/1", i, MEM_A, MEM_WE, BUSY, i); end
      if (i == 1) begin
        START = 1'b1; OP = 1'b1; BASE = 32'd50; STRIDE = 32'd7; VIN = {4{32'hDEAD_BEEF}};
      end else begin
        START = 1'b0;
      end
    end
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin errors++;
      $display("FAIL ignore_done: DONE=%b expected 1", DONE); end
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    checks++; if ({BUSY, DONE, MEM_WE} !== 3'b000) begin errors++;
      $display("FAIL ignore_in_done: busy/done/we=%b expected 000", {BUSY, DONE, MEM_WE}); end
    checks++; if (VOUT !== {32'd40, 32'd30, 32'd4, 32'd3}) begin errors++;
      $display("FAIL ignore_vout: got %h expected lanes 3,4,30,40", VOUT); end
    OP = 1'b0; BASE = '0; STRIDE = '0; VIN = '0;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++;
      $display("FAIL ignore_idle: BUSY=%b expected 0", BUSY); end
  endtask

  task automatic test_reset_abort();
    issue(1'b1, 32'd0, 32'd1, {32'd400, 32'd300, 32'd200, 32'd100});
    repeat (3) @(negedge CLK);
    checks++; if (MEM_A !== 32'd2 || MEM_WE !== 1'b1) begin errors++;
      $display("FAIL abort_pre: A=%0d WE=%b expected 2/1", MEM_A, MEM_WE); end
    RST_N = 1'b0;
    #1;
    checks++; if ({BUSY, MEM_WE, DONE} !== 3'b000 || MEM_A !== 32'd0 || VOUT !== 128'd0) begin errors++;
      $display("FAIL abort_now: busy/we/done=%b A=%h VOUT=%h expected 000/0/0", {BUSY, MEM_WE, DONE}, MEM_A, VOUT); end
    @(posedge CLK); #1;
    checks++; if (DONE !== 1'b0) begin errors++;
      $display("FAIL abort_no_done: DONE=%b expected 0", DONE); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++;
      $display("FAIL abort_after: DONE=%b BUSY=%b expected 0/0", DONE, BUSY); end
    checks++; if (mem[0] !== 32'd100 || mem[1] !== 32'd200 || mem[2] !== 32'd30 || mem[3] !== 32'd40) begin errors++;
      $display("FAIL abort_mem: %0d %0d %0d %0d expected 100 200 30 40", mem[0], mem[1], mem[2], mem[3]); end
    issue(1'b0, 32'd0, 32'd1, '0);
    repeat (4) @(negedge CLK);
    @(negedge CLK);
    checks++; if (DONE !== 1'b1) begin errors++;
      $display("FAIL abort_rerun_done: DONE=%b expected 1", DONE); end
    @(negedge CLK);
    checks++; if (VOUT !== {32'd40, 32'd30, 32'd200, 32'd100}) begin errors++;
      $display("FAIL abort_rerun_vout: got %h expected lanes 100,200,30,40", VOUT); end
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_load_basic();
    test_load_stride();
    test_store_wrap();
    test_start_ignored();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
